// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant of one functional-unit result per
// cycle onto a registered CDB broadcast, with ROB backpressure and flush squash.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROB_IDX_W = 3
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_FU-1:0]             fu_valid_in,
  input  logic [NUM_FU*DATA_W-1:0]      fu_data_in,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx_in,
  output logic [NUM_FU-1:0]             fu_read_out,
  input  logic                          rob_ready_in,
  input  logic                          flush_in,
  output logic                          cdb_valid_out,
  output logic [DATA_W-1:0]             cdb_data_out,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx_out,
  output logic [2:0]                    cdb_src_out
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SRC_W = 3;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 grant_en;
  logic                 accept;
  logic [NUM_FU-1:0]    grant_oh;
  logic [DATA_W-1:0]    sel_data;
  logic [ROB_IDX_W-1:0] sel_rob_idx;

  // The output register can take a new result when empty or being consumed.
  assign accept   = rob_ready_in || !cdb_valid_out;
  assign grant_en = rst_in && !flush_in && accept;

  // Rotating scan starting at ptr; the first requester found wins.
  always_comb begin : rr_scan
    int unsigned pos;
    pos       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_FU) pos = pos - NUM_FU;
      if (grant_en && !grant_any && fu_valid_in[PTR_W'(pos)]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(pos);
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  // One-hot select of the granted FU's payload.
  always_comb begin : payload_mux
    sel_data    = '0;
    sel_rob_idx = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (grant_oh[i]) begin
        sel_data    = fu_data_in[i*DATA_W +: DATA_W];
        sel_rob_idx = fu_rob_idx_in[i*ROB_IDX_W +: ROB_IDX_W];
      end
    end
  end

  assign ptr_nxt     = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
  assign fu_read_out = grant_oh;

  // CDB output register and priority pointer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr             <= '0;
      cdb_valid_out   <= 1'b0;
      cdb_data_out    <= '0;
      cdb_rob_idx_out <= '0;
      cdb_src_out     <= '0;
    end else if (flush_in) begin
      cdb_valid_out <= 1'b0;
    end else if (accept) begin
      if (grant_any) begin
        cdb_valid_out   <= 1'b1;
        cdb_data_out    <= sel_data;
        cdb_rob_idx_out <= sel_rob_idx;
        cdb_src_out     <= SRC_W'(grant_idx);
        ptr             <= ptr_nxt;
      end else begin
        cdb_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: FU result slots driven by the bench,
// a spec-level round-robin model checked every cycle, plus directed scenarios.
module tb_cdb_arbiter;

  localparam int unsigned NUM_FU    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_IDX_W = 3;
  localparam int          NFU       = 5;

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b0;
  logic [NUM_FU-1:0]           fu_valid_in = '0;
  logic [NUM_FU*DATA_W-1:0]    fu_data_in = '0;
  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_in = '0;
  logic [NUM_FU-1:0]           fu_read_out;
  logic                        rob_ready_in = 1'b1;
  logic                        flush_in = 1'b0;
  logic                        cdb_valid_out;
  logic [DATA_W-1:0]           cdb_data_out;
  logic [ROB_IDX_W-1:0]        cdb_rob_idx_out;
  logic [2:0]                  cdb_src_out;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .fu_valid_in     (fu_valid_in),
    .fu_data_in      (fu_data_in),
    .fu_rob_idx_in   (fu_rob_idx_in),
    .fu_read_out     (fu_read_out),
    .rob_ready_in    (rob_ready_in),
    .flush_in        (flush_in),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_data_out    (cdb_data_out),
    .cdb_rob_idx_out (cdb_rob_idx_out),
    .cdb_src_out     (cdb_src_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side FU result slots (each FU holds one result until read).
  logic        slot_v [NFU];
  logic [31:0] slot_d [NFU];
  logic [2:0]  slot_r [NFU];
  int          fu_left[NFU];
  int          fu_seq [NFU];

  // Model state.
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic [2:0]  m_idx = '0;
  int          m_src = 0;
  int          last_grant = -1;
  int          exp_g;
  int          grant_log[$];

  function automatic int model_grant(input logic [NUM_FU-1:0] req, input int p,
                                     input logic busy, input logic ready,
                                     input logic flush, input logic rstn);
    if (!rstn || flush) return -1;
    if (busy && !ready) return -1;
    for (int k = 0; k < NFU; k++) begin
      int j;
      j = (p + k) % NFU;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  always_comb exp_g = model_grant(fu_valid_in, m_ptr, m_valid, rob_ready_in, flush_in, rst_in);

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_ptr      <= 0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_idx      <= '0;
      m_src      <= 0;
      last_grant <= -1;
    end else begin
      last_grant <= exp_g;
      if (flush_in) begin
        m_valid <= 1'b0;
      end else if (rob_ready_in || !m_valid) begin
        if (exp_g >= 0) begin
          m_valid <= 1'b1;
          m_data  <= slot_d[exp_g];
          m_idx   <= slot_r[exp_g];
          m_src   <= exp_g;
          m_ptr   <= (exp_g + 1) % NFU;
          grant_log.push_back(exp_g);
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("cyc_read", 64'(fu_read_out), (exp_g >= 0) ? (64'd1 << exp_g) : 64'd0);
      chk("cyc_valid", 64'(cdb_valid_out), 64'(m_valid));
      chk("cyc_data", 64'(cdb_data_out), 64'(m_data));
      chk("cyc_rob_idx", 64'(cdb_rob_idx_out), 64'(m_idx));
      chk("cyc_src", 64'(cdb_src_out), 64'(m_src));
    end
  end

  task automatic drive_fus();
    for (int i = 0; i < NFU; i++) begin
      fu_valid_in[i]                      = slot_v[i];
      fu_data_in[i*DATA_W +: DATA_W]      = slot_d[i];
      fu_rob_idx_in[i*ROB_IDX_W +: ROB_IDX_W] = slot_r[i];
    end
  endtask

  task automatic post(input int i, input logic [31:0] d, input logic [2:0] r);
    slot_v[i] = 1'b1;
    slot_d[i] = d;
    slot_r[i] = r;
    drive_fus();
  endtask

  // Advance one cycle: FUs drop (or refill) results read at the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
    for (int i = 0; i < NFU; i++) begin
      if (last_grant == i) begin
        slot_v[i] = 1'b0;
        if (fu_left[i] > 0) begin
          fu_left[i]--;
          fu_seq[i]++;
          slot_v[i] = 1'b1;
          slot_d[i] = 32'hF000_0000 + 32'(i) * 32'h100 + 32'(fu_seq[i]);
          slot_r[i] = 3'(fu_seq[i]);
        end
      end
    end
    drive_fus();
    #1;
  endtask

  task automatic reset_pulse();
    rst_in = 1'b0;
    #1;
    rst_in = 1'b1;
  endtask

  initial begin
    int cnt[NFU];
    int exp_order[10];
    for (int i = 0; i < NFU; i++) begin
      slot_v[i] = 1'b0; slot_d[i] = '0; slot_r[i] = '0; fu_left[i] = 0; fu_seq[i] = 0;
    end
    drive_fus();
    repeat (2) @(posedge clk_in);
    #2;
    chk("rst_valid", 64'(cdb_valid_out), 64'd0);
    chk("rst_data", 64'(cdb_data_out), 64'd0);
    chk("rst_src", 64'(cdb_src_out), 64'd0);
    chk("rst_read", 64'(fu_read_out), 64'd0);
    chk("rst_ptr", 64'(dut.ptr), 64'd0);
    rst_in = 1'b1;

    // Single request
    post(2, 32'h0000_00A5, 3'd3);
    #1;
    chk("t1_read", 64'(fu_read_out), 64'b00100);
    tick();
    chk("t1_valid", 64'(cdb_valid_out), 64'd1);
    chk("t1_data", 64'(cdb_data_out), 64'hA5);
    chk("t1_idx", 64'(cdb_rob_idx_out), 64'd3);
    chk("t1_src", 64'(cdb_src_out), 64'd2);
    tick();
    chk("t1_idle", 64'(cdb_valid_out), 64'd0);
    chk("t1_ptr", 64'(dut.ptr), 64'd3);
    chk("t1_mptr", 64'(m_ptr), 64'd3);

    // Simultaneous requests from reset
    reset_pulse();
    post(0, 32'h1111, 3'd1);
    post(3, 32'h3333, 3'd5);
    #1;
    chk("t2_read0", 64'(fu_read_out), 64'b00001);
    tick();
    chk("t2_read3", 64'(fu_read_out), 64'b01000);
    chk("t2_src0", 64'(cdb_src_out), 64'd0);
    chk("t2_data0", 64'(cdb_data_out), 64'h1111);
    tick();
    chk("t2_src3", 64'(cdb_src_out), 64'd3);
    chk("t2_valid3", 64'(cdb_valid_out), 64'd1);
    chk("t2_idx3", 64'(cdb_rob_idx_out), 64'd5);
    chk("t2_ptr", 64'(dut.ptr), 64'd4);
    tick();
    chk("t2_idle", 64'(cdb_valid_out), 64'd0);

    // Saturation: all FUs requesting for 10 cycles
    reset_pulse();
    grant_log.delete();
    for (int i = 0; i < NFU; i++) begin
      fu_left[i] = 1;
      post(i, 32'hF000_0000 + 32'(i) * 32'h100, 3'(i));
    end
    #1;
    repeat (10) tick();
    exp_order = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    chk("t3_count", 64'(grant_log.size()), 64'd10);
    for (int i = 0; i < NFU; i++) cnt[i] = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < grant_log.size()) begin
        chk("t3_order", 64'(grant_log[k]), 64'(exp_order[k]));
        cnt[grant_log[k]]++;
      end
    end
    for (int i = 0; i < NFU; i++) chk("t3_twice", 64'(cnt[i]), 64'd2);
    chk("t3_ptr", 64'(dut.ptr), 64'd0);

    // Backpressure
    post(1, 32'h0000_00B1, 3'd2);
    #1;
    chk("t4_read1", 64'(fu_read_out), 64'b00010);
    tick();
    rob_ready_in = 1'b0;
    post(2, 32'h0000_00C2, 3'd6);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_stall_read", 64'(fu_read_out), 64'd0);
      chk("t4_hold_valid", 64'(cdb_valid_out), 64'd1);
      chk("t4_hold_src", 64'(cdb_src_out), 64'd1);
      chk("t4_hold_data", 64'(cdb_data_out), 64'hB1);
      if (c < 2) tick();
    end
    tick();
    rob_ready_in = 1'b1;
    #1;
    chk("t4_read2", 64'(fu_read_out), 64'b00100);
    chk("t4_still_src1", 64'(cdb_src_out), 64'd1);
    tick();
    chk("t4_src2", 64'(cdb_src_out), 64'd2);
    chk("t4_data2", 64'(cdb_data_out), 64'hC2);
    chk("t4_idx2", 64'(cdb_rob_idx_out), 64'd6);

    // Flush
    post(3, 32'h0000_00D3, 3'd7);
    #1;
    chk("t5_read3", 64'(fu_read_out), 64'b01000);
    tick();
    chk("t5_valid3", 64'(cdb_valid_out), 64'd1);
    flush_in = 1'b1;
    post(4, 32'h0000_00E4, 3'd0);
    #1;
    chk("t5_flush_read", 64'(fu_read_out), 64'd0);
    tick();
    flush_in = 1'b0;
    #1;
    chk("t5_squash", 64'(cdb_valid_out), 64'd0);
    chk("t5_ptr", 64'(dut.ptr), 64'd4);
    chk("t5_read4", 64'(fu_read_out), 64'b10000);
    tick();
    chk("t5_src4", 64'(cdb_src_out), 64'd4);
    chk("t5_data4", 64'(cdb_data_out), 64'hE4);

    // Async reset mid-broadcast
    post(2, 32'h0000_0077, 3'd4);
    #1;
    chk("t6_read2", 64'(fu_read_out), 64'b00100);
    tick();
    chk("t6_valid", 64'(cdb_valid_out), 64'd1);
    chk("t6_ptr3", 64'(dut.ptr), 64'd3);
    rst_in = 1'b0;
    post(3, 32'h0000_0033, 3'd2);
    #1;
    chk("t6_rst_valid", 64'(cdb_valid_out), 64'd0);
    chk("t6_rst_data", 64'(cdb_data_out), 64'd0);
    chk("t6_rst_idx", 64'(cdb_rob_idx_out), 64'd0);
    chk("t6_rst_src", 64'(cdb_src_out), 64'd0);
    chk("t6_rst_read", 64'(fu_read_out), 64'd0);
    chk("t6_rst_ptr", 64'(dut.ptr), 64'd0);
    tick();
    rst_in = 1'b1;
    post(0, 32'h0000_0099, 3'd1);
    #1;
    chk("t6_read0", 64'(fu_read_out), 64'b00001);
    tick();
    chk("t6_src0", 64'(cdb_src_out), 64'd0);
    chk("t6_data0", 64'(cdb_data_out), 64'h99);
    tick();
    chk("t6_src3", 64'(cdb_src_out), 64'd3);
    tick();
    chk("t6_idle", 64'(cdb_valid_out), 64'd0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus (CDB) arbiter for the Tomasulo superscalar core. It is the consumer end of the functional-unit result handshake: each FU (alu, brAlu, mul, div, mem) raises `valid_out` and holds its result until it sees `read_in`. The arbiter grants at most one FU per cycle, round-robin, and drives `read_in` to that FU. It broadcasts the granted result and its ROB index on a registered CDB to the ROB, the register file and the reservation stations.

## Interface
Parameters:
- NUM_FU, 5, number of result-producing FUs; index 0=alu, 1=brAlu, 2=mul, 3=div, 4=mem
- DATA_W, 32, result width
- ROB_IDX_W, 3, ROB index width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- fu_valid_in  input  NUM_FU  bit i = FU i holds a result (FU `valid_out`)
- fu_data_in  input  NUM_FU*DATA_W  FU i result at [i*DATA_W +: DATA_W]
- fu_rob_idx_in  input  NUM_FU*ROB_IDX_W  FU i ROB index at [i*ROB_IDX_W +: ROB_IDX_W]
- fu_read_out  output  NUM_FU  one-hot grant; drives FU i `read_in`
- rob_ready_in  input  1  CDB consumer can accept a broadcast this cycle
- flush_in  input  1  mispredict flush; squash the pending broadcast and any grant
- cdb_valid_out  output  1  CDB carries a result
- cdb_data_out  output  DATA_W  broadcast result
- cdb_rob_idx_out  output  ROB_IDX_W  broadcast ROB index
- cdb_src_out  output  3  index of the FU that produced the broadcast

## Operation
- State: priority pointer `ptr` (0..NUM_FU-1), CDB output register (valid, data, rob_idx, src).
- `accept` = rob_ready_in || !cdb_valid_out (output register empty or being consumed).
- Grant (combinational, same cycle):
  - If flush_in=0, accept=1 and rst_in=1, grant the first i with fu_valid_in[i]=1, scanning ptr, ptr+1, …, wrapping mod NUM_FU.
  - fu_read_out is one-hot at that i; it is all-zero when there is no request, accept=0, flush_in=1, or rst_in=0.
- On a grant to i, at the next edge:
  - CDB register loads {1, data_i, rob_idx_i, i}.
  - ptr <= (i+1) mod NUM_FU.
- Accept with no grant: cdb_valid_out <= 0; data, rob_idx and src hold their last values.
- accept=0 (ROB stalled with a valid broadcast): CDB register and ptr hold; no grants; FUs keep valid high.
- flush_in=1: at the next edge cdb_valid_out <= 0; ptr holds; no grant. Flush overrides rob_ready_in. Squashing FU-internal results is the FUs' job.
- Requests from FU indices ≥ NUM_FU do not exist. fu_valid_in bits whose data changes while unread are an FU protocol violation; the arbiter samples data only on the grant cycle.

## Timing
- Reset (rst_in=0, asynchronous): cdb_valid_out=0, cdb_data_out=0, cdb_rob_idx_out=0, cdb_src_out=0, ptr=0, fu_read_out=0 immediately. First grant is possible in the first cycle with rst_in=1.
- Latency: FU valid in cycle t and granted → fu_read_out[i]=1 in cycle t → cdb_valid_out=1 with that result in cycle t+1. The FU drops valid at the edge ending t.
- Throughput: one broadcast per cycle while rob_ready_in=1. Back-to-back grants to different FUs in consecutive cycles are allowed.
- A broadcast with rob_ready_in=1 lasts exactly one cycle. A broadcast with rob_ready_in=0 is held stable until the first cycle rob_ready_in=1; the result is consumed in that cycle, and a new grant may load in the same cycle.
- Fairness: with all NUM_FU requesting continuously, each FU is granted exactly once per NUM_FU cycles.
- ptr wraps from NUM_FU-1 to 0.

## Test plan
- Single request: rob_ready_in=1, fu_valid_in=5'b00100 with data 0x0000_00A5 and rob_idx 3, held until read → fu_read_out=5'b00100 that cycle. Next cycle: cdb_valid_out=1, data 0xA5, rob_idx 3, src 2. Following cycle: cdb_valid_out=0. ptr=3.
- Simultaneous requests: from reset, FU0 and FU3 valid in the same cycle → FU0 granted first, FU3 next cycle. CDB shows src 0 then src 3 in consecutive cycles; ptr ends at 4.
- Saturation: all 5 FUs valid continuously for 10 cycles → grant order 0,1,2,3,4,0,1,2,3,4; each FU granted exactly twice.
- Backpressure: CDB valid with src 1, rob_ready_in=0 for 3 cycles while FU2 requests → fu_read_out=0 and CDB held for those 3 cycles. On rob_ready_in=1, FU2 is granted the same cycle and broadcast the next.
- Flush: FU4 valid and flush_in=1 in the same cycle as a valid CDB → fu_read_out=0, cdb_valid_out=0 next cycle, ptr unchanged. FU4 is granted in the first cycle after flush_in drops.
- Async reset mid-broadcast: drop rst_in while cdb_valid_out=1 and ptr=3 → all outputs 0 and ptr=0 without waiting for a clock edge. After release, FU0 wins over FU3 when both request.
